mem_responder: RTL and testbench

- Memory-side responder for the core's load/store and fetch traffic: accepts one request at a time over a valid/ready request channel, performs a sized read or write on a doubleword-wide RAM, returns a response over a valid/ready response channel.
- Replaces the core's inline instruction array and supplies the missing data-memory path for RV64 LB/LH/LW/LD(U) and SB/SH/SW/SD.
- Single outstanding transaction; fixed, parameterised access latency.

---
 rtl/mem_pkg.sv | 49 ++++
 rtl/mem_responder_load_align.sv | 32 +++
 rtl/mem_responder.sv | 136 +++++++++++++
 tb/tb_mem_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory responder slice.
//   - SZ_B/SZ_H/SZ_W/SZ_D : access size encodings carried on req_size
//   - DEFAULT_BASE_ADDR   : byte address of doubleword 0
//   - respState_e         : responder FSM states
//   - alignMask/laneEnables : size-derived helpers for alignment and byte enables
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } respState_e;

  // Low lane bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] alignMask(input logic [1:0] size);
    logic [2:0] mask;
    mask = 3'b000;
    case (size)
      SZ_B: mask = 3'b000;
      SZ_H: mask = 3'b001;
      SZ_W: mask = 3'b011;
      SZ_D: mask = 3'b111;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

  // Byte enables for an access of this size starting at lane 0.
  function automatic logic [7:0] laneEnables(input logic [1:0] size);
    logic [7:0] en;
    en = 8'h00;
    case (size)
      SZ_B: en = 8'h01;
      SZ_H: en = 8'h03;
      SZ_W: en = 8'h0F;
      SZ_D: en = 8'hFF;
      default: en = 8'h00;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/mem_responder_load_align.sv
// load_align: combinational load data extraction.
// Ports:
//   dword   in  64  doubleword read from the RAM
//   lane    in  3   byte offset of the access within the doubleword
//   size    in  2   access size (SZ_B/SZ_H/SZ_W/SZ_D)
//   zeroExt in  1   zero-extend instead of sign-extend (ignored for SZ_D)
//   result  out 64  selected bytes right-justified and extended
module load_align
  import mem_pkg::*;
(
  input  logic [63:0] dword,
  input  logic [2:0]  lane,
  input  logic [1:0]  size,
  input  logic        zeroExt,
  output logic [63:0] result
);

  logic [63:0] shifted;

  // Bring the addressed lane down to byte 0, then extend from the access width.
  always_comb begin
    shifted = dword >> {lane, 3'b000};
    result  = shifted;
    case (size)
      SZ_B: result = zeroExt ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      SZ_H: result = zeroExt ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      SZ_W: result = zeroExt ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder over a doubleword RAM.
// Accepts one request on a valid/ready channel, performs a sized load or store,
// and returns the result on a valid/ready response channel LATENCY cycles later.
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_we, req_addr, req_size, req_unsigned, req_wdata  request fields
//   resp_valid/resp_ready      response handshake
//   resp_rdata, resp_err       load result (0 for stores/errors) and error flag
module mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH     = 4096,
  parameter logic [63:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          LATENCY   = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // WAIT runs LATENCY-1 cycles; the counter is loaded with one less than that.
  localparam logic [3:0] WAIT_LOAD = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

  logic [63:0] ram [DEPTH];

  respState_e       state;
  logic [3:0]       waitCount;
  logic [63:0]      offset;
  logic [2:0]       lane;
  logic [IDX_W-1:0] ramIdx;
  logic             outOfRange;
  logic             misaligned;
  logic             reqErr;
  logic             accept;
  logic [63:0]      loadData;
  logic [7:0]       storeEnables;
  logic [63:0]      storeData;

  // Decode the live request. The whole response is formed in the handshake
  // cycle, so nothing about the request needs to be kept beyond that.
  always_comb begin
    offset       = req_addr - BASE_ADDR;
    lane         = offset[2:0];
    ramIdx       = offset[IDX_W+2:3];
    outOfRange   = (req_addr < BASE_ADDR) || ({3'b000, offset[63:3]} >= 64'(DEPTH));
    misaligned   = (lane & alignMask(req_size)) != 3'b000;
    reqErr       = outOfRange || misaligned;
    accept       = req_valid && req_ready;
    storeEnables = laneEnables(req_size) << lane;
    storeData    = req_wdata << {lane, 3'b000};
  end

  load_align uLoadAlign (
    .dword  (ram[ramIdx]),
    .lane   (lane),
    .size   (req_size),
    .zeroExt(req_unsigned),
    .result (loadData)
  );

  // Stores commit at the handshake; only the enabled byte lanes change and a
  // faulting store never touches the array.
  always_ff @(posedge clk) begin
    if (accept && req_we && !reqErr) begin
      for (int b = 0; b < 8; b++) begin
        if (storeEnables[b]) ram[ramIdx][8*b +: 8] <= storeData[8*b +: 8];
      end
    end
  end

  // Control FSM with registered outputs. req_ready rises one cycle after
  // entering IDLE from reset and immediately after a response handshake, so a
  // request can never be accepted in the same cycle a response completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      waitCount  <= 4'd0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready  <= 1'b0;
            resp_err   <= reqErr;
            resp_rdata <= (reqErr || req_we) ? 64'd0 : loadData;
            if (LATENCY <= 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state     <= WAIT;
              waitCount <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (waitCount == 4'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            waitCount <= waitCount - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for mem_responder.
// Drives a LATENCY=2 instance through stores, sized loads, error cases,
// backpressure and mid-transaction reset, then a LATENCY=1 instance through
// back-to-back word loads with resp_ready tied high.
module tb_mem_responder;

  localparam int LAT = 2;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    string       tag;
  } Exp_t;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;

  logic        req1Valid, req1Ready, req1We, req1Unsigned;
  logic [63:0] req1Addr, req1Wdata;
  logic [1:0]  req1Size;
  logic        resp1Valid, resp1Ready, resp1Err;
  logic [63:0] resp1Rdata;

  Exp_t expQ[$];
  Exp_t exp1Q[$];
  int assertCount = 0;
  int failCount   = 0;

  mem_responder #(.DEPTH(4096), .BASE_ADDR(64'h8000_0000), .LATENCY(LAT), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  mem_responder #(.DEPTH(64), .BASE_ADDR(64'h8000_0000), .LATENCY(1), .INIT_FILE("")) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req1Valid), .req_ready(req1Ready), .req_we(req1We),
    .req_addr(req1Addr), .req_size(req1Size), .req_unsigned(req1Unsigned),
    .req_wdata(req1Wdata),
    .resp_valid(resp1Valid), .resp_ready(resp1Ready),
    .resp_rdata(resp1Rdata), .resp_err(resp1Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Back-to-back table for the LATENCY=1 instance.
  logic        weTab   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [63:0] addrTab [6] = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0000,
                               64'h8000_0000, 64'h8000_0004, 64'h8000_0000};
  logic [1:0]  sizeTab [6] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
  logic        unsTab  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [63:0] wdTab   [6] = '{64'hCAFE_BABE_8000_0000, 64'h0000_0000_1234_5678,
                               64'd0, 64'd0, 64'd0, 64'd0};
  logic [63:0] expTab  [6] = '{64'd0, 64'd0, 64'h0000_0000_8000_0000,
                               64'hFFFF_FFFF_8000_0000, 64'h0000_0000_1234_5678,
                               64'h1234_5678_8000_0000};

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Present a request, wait (bounded) for acceptance, record the expected response.
  task automatic applyStimulus(input string tag, input logic we, input logic [63:0] addr,
                               input logic [1:0] size, input logic uns, input logic [63:0] wdata,
                               input logic [63:0] expRdata, input logic expErr);
    int budget;
    Exp_t e;
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    budget = 0;
    while (req_ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    checkOutput({tag, " accepted"}, 64'(budget < 20), 64'd1);
    e.rdata = expRdata; e.err = expErr; e.tag = tag;
    expQ.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait for the response, compare against the scoreboard, optionally hold it
  // under backpressure, then complete the handshake and check the ready return.
  task automatic awaitResponse(input int hold);
    int cycles;
    Exp_t e;
    cycles = 1;
    while (resp_valid !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    if (expQ.size() == 0) begin
      checkOutput("scoreboard nonempty", 64'd0, 64'd1);
      return;
    end
    e = expQ.pop_front();
    checkOutput({e.tag, " latency"}, 64'(cycles), 64'(LAT));
    checkOutput({e.tag, " rdata"}, resp_rdata, e.rdata);
    checkOutput({e.tag, " err"}, 64'(resp_err), 64'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({e.tag, " hold valid"}, 64'(resp_valid), 64'd1);
      checkOutput({e.tag, " hold rdata"}, resp_rdata, e.rdata);
      checkOutput({e.tag, " hold err"}, 64'(resp_err), 64'(e.err));
      checkOutput({e.tag, " hold req_ready"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput({e.tag, " valid dropped"}, 64'(resp_valid), 64'd0);
    checkOutput({e.tag, " ready returned"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 64'd0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 64'd0; resp_ready = 1'b0;
    req1Valid = 1'b0; req1We = 1'b0; req1Addr = 64'd0; req1Size = 2'd0;
    req1Unsigned = 1'b0; req1Wdata = 64'd0; resp1Ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset req_ready", 64'(req_ready), 64'd0);
    checkOutput("reset resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("reset resp_rdata", resp_rdata, 64'd0);
    checkOutput("reset resp_err", 64'(resp_err), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("ready after release", 64'(req_ready), 64'd1);

    // Full doubleword store and load back
    applyStimulus("SD", 1'b1, 64'h8000_0010, 2'd3, 1'b0, 64'h1122_3344_5566_7788, 64'd0, 1'b0);
    awaitResponse(0);
    applyStimulus("LD", 1'b0, 64'h8000_0010, 2'd3, 1'b0, 64'd0, 64'h1122_3344_5566_7788, 1'b0);
    awaitResponse(0);

    // Byte store merges into the doubleword; only wdata[7:0] is used
    applyStimulus("SB", 1'b1, 64'h8000_0013, 2'd0, 1'b0, 64'h5555_5555_5555_55AA, 64'd0, 1'b0);
    awaitResponse(0);
    applyStimulus("LD merged", 1'b0, 64'h8000_0010, 2'd3, 1'b0, 64'd0, 64'h1122_3344_AA66_7788, 1'b0);
    awaitResponse(0);
    applyStimulus("LB", 1'b0, 64'h8000_0013, 2'd0, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFAA, 1'b0);
    awaitResponse(0);
    applyStimulus("LBU", 1'b0, 64'h8000_0013, 2'd0, 1'b1, 64'd0, 64'h0000_0000_0000_00AA, 1'b0);
    awaitResponse(0);
    applyStimulus("LH", 1'b0, 64'h8000_0012, 2'd1, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_AA66, 1'b0);
    awaitResponse(0);
    applyStimulus("LW upper", 1'b0, 64'h8000_0014, 2'd2, 1'b0, 64'd0, 64'h0000_0000_1122_3344, 1'b0);
    awaitResponse(0);

    // Errors: misaligned load/store, below base, past the end
    applyStimulus("LW misaligned", 1'b0, 64'h8000_0012, 2'd2, 1'b0, 64'd0, 64'd0, 1'b1);
    awaitResponse(0);
    applyStimulus("SW misaligned", 1'b1, 64'h8000_0012, 2'd2, 1'b0, 64'h0000_0000_DEAD_BEEF, 64'd0, 1'b1);
    awaitResponse(0);
    applyStimulus("LD after bad SW", 1'b0, 64'h8000_0010, 2'd3, 1'b0, 64'd0, 64'h1122_3344_AA66_7788, 1'b0);
    awaitResponse(0);
    applyStimulus("LD below base", 1'b0, 64'h7FFF_FFF8, 2'd3, 1'b0, 64'd0, 64'd0, 1'b1);
    awaitResponse(0);
    applyStimulus("LD past end", 1'b0, 64'h8000_8000, 2'd3, 1'b0, 64'd0, 64'd0, 1'b1);
    awaitResponse(0);
    applyStimulus("SD last", 1'b1, 64'h8000_7FF8, 2'd3, 1'b0, 64'h8000_0000_0000_0001, 64'd0, 1'b0);
    awaitResponse(0);
    applyStimulus("LD last", 1'b0, 64'h8000_7FF8, 2'd3, 1'b0, 64'd0, 64'h8000_0000_0000_0001, 1'b0);
    awaitResponse(0);

    // Backpressure for 5 cycles with a new request already waiting
    applyStimulus("LD held", 1'b0, 64'h8000_0010, 2'd3, 1'b0, 64'd0, 64'h1122_3344_AA66_7788, 1'b0);
    req_we = 1'b0; req_addr = 64'h8000_0014; req_size = 2'd2; req_unsigned = 1'b1; req_valid = 1'b1;
    awaitResponse(5);
    applyStimulus("LWU pending", 1'b0, 64'h8000_0014, 2'd2, 1'b1, 64'd0, 64'h0000_0000_1122_3344, 1'b0);
    awaitResponse(0);

    // Reset while a load is in WAIT: the transaction is dropped
    applyStimulus("LD abandoned", 1'b0, 64'h8000_0010, 2'd3, 1'b0, 64'd0, 64'd0, 1'b0);
    void'(expQ.pop_back());
    reset = 1'b1;
    #1;
    checkOutput("mid reset req_ready", 64'(req_ready), 64'd0);
    checkOutput("mid reset resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abandoned no resp 0", 64'(resp_valid), 64'd0);
    @(negedge clk);
    checkOutput("ready after mid reset", 64'(req_ready), 64'd1);
    checkOutput("abandoned no resp 1", 64'(resp_valid), 64'd0);
    applyStimulus("LD after reset", 1'b0, 64'h8000_0010, 2'd3, 1'b0, 64'd0, 64'h1122_3344_AA66_7788, 1'b0);
    awaitResponse(0);

    // LATENCY=1 instance: one response every 2 cycles with resp_ready tied high
    for (int i = 0; i < 6; i++) begin
      Exp_t e;
      req1We = weTab[i]; req1Addr = addrTab[i]; req1Size = sizeTab[i];
      req1Unsigned = unsTab[i]; req1Wdata = wdTab[i]; req1Valid = 1'b1;
      checkOutput($sformatf("lat1 req%0d ready", i), 64'(req1Ready), 64'd1);
      e.rdata = expTab[i]; e.err = 1'b0; e.tag = $sformatf("lat1 req%0d", i);
      exp1Q.push_back(e);
      @(negedge clk);
      e = exp1Q.pop_front();
      checkOutput({e.tag, " valid"}, 64'(resp1Valid), 64'd1);
      checkOutput({e.tag, " rdata"}, resp1Rdata, e.rdata);
      checkOutput({e.tag, " err"}, 64'(resp1Err), 64'(e.err));
      checkOutput({e.tag, " busy"}, 64'(req1Ready), 64'd0);
      @(negedge clk);
    end
    req1Valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
